// File: rtl/display_planes.sv
// display_planes: multi-plane framebuffer scan-out with pixel replication.
// Define DISPLAY_PALETTE_EN for a writable four-entry palette.
module display_planes #(
   parameter int PLANES     = 2,
   parameter int WORD_W     = 16,
   parameter int ADDR_W     = 10,
   parameter int FIELD_W_LO = 64,
   parameter int FIELD_H_LO = 32,
   parameter int FIELD_W_HI = 128,
   parameter int FIELD_H_HI = 64,
   parameter int HMULT_LO   = 10,
   parameter int HMULT_HI   = 5,
   parameter int VMULT_LO   = 12,
   parameter int VMULT_HI   = 6,
   parameter int Y0         = 48,
   parameter int Y_LAST     = 479
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     hires,
   input  logic                     frameStart,
   input  logic                     lineStart,
   input  logic                     pixelEnable,
   input  logic [10:0]              pixelY,
   output logic [ADDR_W-1:0]        fbAddr,
   output logic                     fbRe,
   input  logic [PLANES*WORD_W-1:0] fbData,
   output logic [2:0]               r,
   output logic [2:0]               g,
   output logic [1:0]               b,
   output logic                     outsidePlayfield
`ifdef DISPLAY_PALETTE_EN
   ,
   input  logic                     palWe,
   input  logic [1:0]               palIdx,
   input  logic [7:0]               palData
`endif
);

   localparam int CW = 8;
   localparam int BW = $clog2(WORD_W);
   localparam int WC = $clog2(FIELD_W_HI / WORD_W) + 2;

   localparam logic [10:0] Y0_V    = 11'(Y0);
   localparam logic [10:0] YLAST_V = 11'(Y_LAST);
   localparam logic [10:0] YEND_LO =
      11'(Y0 + FIELD_H_LO * VMULT_LO);
   localparam logic [10:0] YEND_HI =
      11'(Y0 + FIELD_H_HI * VMULT_HI);

   typedef enum logic [2:0] {
      IDLE, FETCH0, PRIME, RUN, DONE
   } state_t;

   state_t state, state_nx;

   logic                     mode_r;
   logic                     blank;
   logic                     hold_ld;
   logic [CW-1:0]            h_cnt;
   logic [CW-1:0]            v_cnt;
   logic [BW-1:0]            bit_cnt;
   logic [WC-1:0]            word_cnt;
   logic [ADDR_W-1:0]        line_addr;
   logic [ADDR_W-1:0]        addr_q;
   logic [PLANES*WORD_W-1:0] sh;
   logic [PLANES*WORD_W-1:0] hold;

   logic [CW-1:0]     hmult_m1;
   logic [CW-1:0]     vmult_m1;
   logic [CW-1:0]     vmult_m1_new;
   logic [WC-1:0]     words_m1;
   logic [ADDR_W-1:0] row_words;
   logic [10:0]       y_end;

   logic       in_field;
   logic       run_px;
   logic       h_wrap;
   logic       bit_wrap;
   logic       last_word;
   logic       fetch_more;
   logic       rd_run;
   logic       show;
   logic [1:0] idx;
   logic [7:0] colour;
   logic [7:0] pix;

   // geometry of the latched mode (and of the incoming one at frameStart)
   always_comb begin
      hmult_m1 = mode_r ? CW'(HMULT_HI - 1)
                        : CW'(HMULT_LO - 1);
      vmult_m1 = mode_r ? CW'(VMULT_HI - 1)
                        : CW'(VMULT_LO - 1);
      vmult_m1_new = hires ? CW'(VMULT_HI - 1)
                           : CW'(VMULT_LO - 1);
      words_m1 = mode_r ? WC'(FIELD_W_HI / WORD_W - 1)
                        : WC'(FIELD_W_LO / WORD_W - 1);
      row_words = mode_r ? ADDR_W'(FIELD_W_HI / WORD_W)
                         : ADDR_W'(FIELD_W_LO / WORD_W);
      y_end = mode_r ? YEND_HI : YEND_LO;
   end

   assign in_field = (pixelY >= Y0_V) && (pixelY < y_end);
   assign outsidePlayfield = !in_field;

   assign run_px = (state == RUN) && pixelEnable &&
                   !frameStart && !lineStart;
   assign h_wrap    = (h_cnt == hmult_m1);
   assign bit_wrap  = (bit_cnt == BW'(WORD_W - 1));
   assign last_word = (word_cnt == words_m1);
   assign fetch_more = (word_cnt + WC'(2)) <= words_m1;
   assign rd_run = run_px && h_wrap && bit_wrap &&
                   !last_word && fetch_more;

   // state register
   always_ff @(posedge clk or negedge res) begin
      if (!res) state <= IDLE;
      else      state <= state_nx;
   end

   // next state and fetch strobes; reset forces the bus idle at once
   always_comb begin
      state_nx = state;
      fbRe     = 1'b0;
      fbAddr   = addr_q;
      if (frameStart) begin
         state_nx = IDLE;
      end else if (lineStart) begin
         if (in_field) begin
            state_nx = FETCH0;
            fbRe     = 1'b1;
            fbAddr   = line_addr;
         end else begin
            state_nx = IDLE;
         end
      end else begin
         unique case (state)
            FETCH0: begin
               fbRe     = 1'b1;
               fbAddr   = addr_q + ADDR_W'(1);
               state_nx = PRIME;
            end
            PRIME: state_nx = RUN;
            RUN: begin
               if (pixelEnable && h_wrap && bit_wrap) begin
                  if (last_word) begin
                     state_nx = DONE;
                  end else if (fetch_more) begin
                     fbRe   = 1'b1;
                     fbAddr = addr_q + ADDR_W'(1);
                  end
               end
            end
            default: state_nx = state;
         endcase
      end
      if (!res) begin
         fbRe   = 1'b0;
         fbAddr = '0;
      end
   end

   // frame/line bookkeeping, word pipeline and pixel replication
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         mode_r    <= 1'b0;
         blank     <= 1'b1;
         hold_ld   <= 1'b0;
         h_cnt     <= '0;
         v_cnt     <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         line_addr <= '0;
         addr_q    <= '0;
         sh        <= '0;
         hold      <= '0;
      end else begin
         hold_ld <= rd_run;
         if (fbRe) addr_q <= fbAddr;
         if (hold_ld || (state == PRIME && state_nx == RUN))
            hold <= fbData;
         if (state == FETCH0 && state_nx == PRIME)
            sh <= fbData;
         if (frameStart) begin
            mode_r    <= hires;
            blank     <= 1'b0;
            line_addr <= '0;
            v_cnt     <= vmult_m1_new;
            h_cnt     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
         end else if (lineStart) begin
            h_cnt    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            if (in_field) begin
               if (v_cnt == '0) begin
                  line_addr <= line_addr + row_words;
                  v_cnt     <= vmult_m1;
               end else begin
                  v_cnt <= v_cnt - CW'(1);
               end
            end
         end else if (run_px) begin
            if (!h_wrap) begin
               h_cnt <= h_cnt + CW'(1);
            end else begin
               h_cnt <= '0;
               if (!bit_wrap) begin
                  bit_cnt <= bit_cnt + BW'(1);
                  for (int p = 0; p < PLANES; p++)
                     sh[p*WORD_W +: WORD_W] <=
                        {sh[p*WORD_W +: WORD_W-1], 1'b0};
               end else begin
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + WC'(1);
                  sh       <= hold;
               end
            end
         end
      end
   end

   assign show = in_field && (state == RUN);

   // colour index from the plane MSBs, zero when nothing is shown
   always_comb begin
      idx = '0;
      if (show)
         for (int p = 0; p < PLANES; p++)
            idx[p] = sh[p*WORD_W + WORD_W - 1];
   end

`ifdef DISPLAY_PALETTE_EN
   logic [7:0] pal [4];

   // palette registers, host-writable
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         pal[0] <= 8'h00;
         pal[1] <= 8'hFF;
         pal[2] <= 8'hD9;
         pal[3] <= 8'h6D;
      end else if (palWe) begin
         pal[palIdx] <= palData;
      end
   end

   assign colour = pal[idx];
`else
   // fixed index-to-colour map
   always_comb begin
      unique case (idx)
         2'd0:    colour = 8'h00;
         2'd1:    colour = 8'hFF;
         2'd2:    colour = 8'hD9;
         default: colour = 8'h6D;
      endcase
   end
`endif

   // border override, blanking and pixel gating
   always_comb begin
      pix = 8'h00;
      if (pixelEnable && !blank) begin
         if (pixelY == 11'd0 || pixelY == YLAST_V)
            pix = 8'hFF;
         else
            pix = colour;
      end
   end

   // registered 3-3-2 output
   always_ff @(posedge clk or negedge res) begin
      if (!res) {r, g, b} <= 8'h00;
      else      {r, g, b} <= pix;
   end

endmodule

// File: tb/tb_display_planes.sv
// tb_display_planes: directed checks of scan-out, replication,
// vertical stepping, mode latching, borders and reset.
module tb_display_planes;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        hires = 1'b0;
   logic        frameStart = 1'b0;
   logic        lineStart = 1'b0;
   logic        pixelEnable = 1'b0;
   logic [10:0] pixelY = '0;
   logic [9:0]  fbAddr;
   logic        fbRe;
   logic [31:0] fbData = '0;
   logic [2:0]  r;
   logic [2:0]  g;
   logic [1:0]  b;
   logic        outsidePlayfield;
`ifdef DISPLAY_PALETTE_EN
   logic        palWe = 1'b0;
   logic [1:0]  palIdx = '0;
   logic [7:0]  palData = '0;
`endif

   logic [15:0] mem0 [1024];
   logic [15:0] mem1 [1024];
   logic [7:0]  pix [640];
   logic [9:0]  re_log [1024];
   int          re_cnt = 0;
   int          base = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          ys [4] = '{47, 48, 431, 432};
   logic        yexp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   display_planes dut (
      .clk(clk), .res(res), .hires(hires),
      .frameStart(frameStart), .lineStart(lineStart),
      .pixelEnable(pixelEnable), .pixelY(pixelY),
      .fbAddr(fbAddr), .fbRe(fbRe), .fbData(fbData),
      .r(r), .g(g), .b(b),
`ifdef DISPLAY_PALETTE_EN
      .palWe(palWe), .palIdx(palIdx), .palData(palData),
`endif
      .outsidePlayfield(outsidePlayfield)
   );

   // framebuffer RAM: data valid the cycle after fbRe
   always @(posedge clk)
      if (fbRe) fbData <= {mem1[fbAddr], mem0[fbAddr]};

   // log every read strobe mid-cycle
   always @(negedge clk)
      if (fbRe) begin
         re_log[re_cnt % 1024] = fbAddr;
         re_cnt++;
      end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic fill(input logic [15:0] w0,
                       input logic [15:0] w1);
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = w0;
         mem1[i] = w1;
      end
   endtask

   task automatic frame(input logic h);
      @(posedge clk); #1;
      hires = h;
      frameStart = 1'b1;
      @(posedge clk); #1;
      frameStart = 1'b0;
   endtask

   task automatic line(input int y, input int n);
      @(posedge clk); #1;
      pixelY = 11'(y);
      lineStart = 1'b1;
      base = re_cnt;
      @(posedge clk); #1;
      lineStart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i <= n; i++) begin
         pixelEnable = (i < n);
         @(negedge clk);
         if (i > 0) pix[i-1] = {r, g, b};
         @(posedge clk); #1;
      end
      pixelEnable = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      fill(16'h0000, 16'h0000);
      mem0[0] = 16'h8000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'({r, g, b}), 32'h00);
      check("rst_addr", 32'(fbAddr), 32'h0);
      check("rst_re", 32'(fbRe), 32'h0);
      res = 1'b1;

      frame(1'b0);
      for (int k = 0; k < 12; k++) begin
         line(48 + k, 640);
         check("lo_px0", 32'(pix[0]), 32'hFF);
         check("lo_px9", 32'(pix[9]), 32'hFF);
         check("lo_px10", 32'(pix[10]), 32'h00);
         check("lo_px19", 32'(pix[19]), 32'h00);
         check("lo_addr", 32'(re_log[base % 1024]), 32'h0);
      end
      check("lo_nre", 32'(re_cnt - base), 32'd4);
      check("lo_last_addr",
            32'(re_log[(base + 3) % 1024]), 32'd3);
      line(60, 640);
      check("lo_row1_addr",
            32'(re_log[base % 1024]), 32'd4);
      check("lo_row1_px", 32'(pix[0]), 32'h00);

      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pixelY = 11'(ys[i]);
         @(negedge clk);
         check("outside", 32'(outsidePlayfield),
               32'(yexp[i]));
      end

      @(posedge clk); #1;
      frameStart = 1'b1;
      lineStart = 1'b1;
      pixelY = 11'd61;
      hires = 1'b0;
      @(negedge clk);
      check("coinc_re", 32'(fbRe), 32'h0);
      @(posedge clk); #1;
      frameStart = 1'b0;
      lineStart = 1'b0;
      line(48, 20);
      check("coinc_addr", 32'(re_log[base % 1024]), 32'h0);
      check("coinc_px", 32'(pix[0]), 32'hFF);

      frame(1'b0);
      line(48, 20);
      check("tog_lo9", 32'(pix[9]), 32'hFF);
      check("tog_lo10", 32'(pix[10]), 32'h00);
      hires = 1'b1;
      line(49, 20);
      check("tog_mid9", 32'(pix[9]), 32'hFF);
      check("tog_mid10", 32'(pix[10]), 32'h00);
      frame(1'b1);
      line(48, 20);
      check("tog_hi4", 32'(pix[4]), 32'hFF);
      check("tog_hi5", 32'(pix[5]), 32'h00);

      fill(16'hFFFF, 16'hFFFF);
      frame(1'b1);
      for (int k = 0; k < 6; k++) begin
         line(48 + k, 640);
         check("hi_px0", 32'(pix[0]), 32'h6D);
         check("hi_px320", 32'(pix[320]), 32'h6D);
         check("hi_px639", 32'(pix[639]), 32'h6D);
         check("hi_nre", 32'(re_cnt - base), 32'd8);
         check("hi_addr", 32'(re_log[base % 1024]), 32'h0);
      end
      line(54, 640);
      check("hi_row1_addr", 32'(re_log[base % 1024]), 32'd8);
      check("hi_row1_last",
            32'(re_log[(base + 7) % 1024]), 32'd15);

      line(0, 8);
      check("border_top", 32'(pix[3]), 32'hFF);
      line(479, 8);
      check("border_bot", 32'(pix[3]), 32'hFF);
      line(40, 8);
      check("above_px", 32'(pix[3]), 32'h00);
      check("above_nre", 32'(re_cnt - base), 32'd0);

      frame(1'b1);
      @(posedge clk); #1;
      pixelY = 11'd48;
      lineStart = 1'b1;
      @(posedge clk); #1;
      lineStart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pixelEnable = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      check("pre_rst_rgb", 32'({r, g, b}), 32'h6D);
      check("pre_rst_addr", 32'(fbAddr), 32'd1);
      res = 1'b0;
      #1;
      check("mid_rst_rgb", 32'({r, g, b}), 32'h00);
      check("mid_rst_addr", 32'(fbAddr), 32'h0);
      check("mid_rst_re", 32'(fbRe), 32'h0);
      @(posedge clk); #1;
      check("mid_rst_hold", 32'({r, g, b}), 32'h00);
      pixelEnable = 1'b0;
      res = 1'b1;
      line(48, 16);
      check("post_rst_blank", 32'(pix[0]), 32'h00);
      frame(1'b1);
      line(48, 16);
      check("post_rst_frame", 32'(pix[0]), 32'h6D);

`ifdef DISPLAY_PALETTE_EN
      fill(16'hFFFF, 16'h0000);
      @(posedge clk); #1;
      palWe = 1'b1;
      palIdx = 2'd1;
      palData = 8'h1C;
      @(posedge clk); #1;
      palWe = 1'b0;
      frame(1'b0);
      line(48, 8);
      check("pal_idx1", 32'(pix[0]), 32'h1C);
      line(0, 8);
      check("pal_border", 32'(pix[0]), 32'hFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
